sha256_stream_core: RTL and testbench

Streaming SHA-256 hash engine. It accepts pre-padded 512-bit message blocks as 16 consecutive 32-bit words and compresses each block on the fly, one round per clock. After the final block it emits the 256-bit digest as eight 32-bit words, most significant word (H0) first. It is the top-level hashing datapath; padding and length encoding are done upstream.

---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_stream_core.sv | 165 ++++++++++++++++
 tb/tb_sha256_stream_core.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and FSM encoding for the streaming hash core.
// Optional feature macro used by the core: SHA256_WRITE_STALL_EN.
package sha256_pkg;

  // Working variables / hash words, element [0] is a (or H0), element [7] is h (or H7).
  typedef logic [7:0][31:0] sha_vars_t;

  typedef logic [1:0] sha_fsm_t;
  localparam sha_fsm_t ST_IDLE  = 2'd0;
  localparam sha_fsm_t ST_RUN   = 2'd1;
  localparam sha_fsm_t ST_FINAL = 2'd2;
  localparam sha_fsm_t ST_OUT   = 2'd3;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam sha_vars_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the working variables a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  sha_vars_t   vars_in,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output sha_vars_t   vars_out
);

  logic [31:0] t1_s;
  logic [31:0] t2_s;

  // Round temporaries and the rotated variable set.
  always_comb begin
    t1_s = vars_in[7] + big_sigma1(vars_in[4]) + ch(vars_in[4], vars_in[5], vars_in[6]) + k + w;
    t2_s = big_sigma0(vars_in[0]) + maj(vars_in[0], vars_in[1], vars_in[2]);
    vars_out = {vars_in[6:4], vars_in[3] + t1_s, vars_in[2:0], t1_s + t2_s};
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 engine: 16 words per block, one round per clock, 8-word digest stream.
// Optional feature macro: SHA256_WRITE_STALL_EN (write gaps stall instead of aborting a block).
module sha256_stream_core
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        write_enable,
  input  logic        first_block,
  input  logic        last_block,
  output logic        busy,
  output logic [31:0] digest,
  output logic        output_enable
);

  sha_fsm_t    state_r;
  logic [5:0]  t_r;
  logic [3:0]  out_cnt_r;
  logic        first_r;
  logic        last_r;
  logic        busy_r;
  logic        oe_r;
  logic [31:0] digest_r;
  sha_vars_t   vars_r;
  sha_vars_t   h_r;
  logic [31:0] w_win_r [16];

  sha_vars_t   round_in_s;
  sha_vars_t   round_out_s;
  sha_vars_t   h_base_s;
  logic [31:0] w_s;
  logic [31:0] w_exp_s;
  logic        accept_s;
  logic        shift_s;

  assign busy          = busy_r;
  assign digest        = digest_r;
  assign output_enable = oe_r;

  sha256_round u_round (
    .vars_in  (round_in_s),
    .w        (w_s),
    .k        (K[t_r]),
    .vars_out (round_out_s)
  );

  // Round operand selection: word 0 seeds a..h from IV or the chained H.
  always_comb begin
    w_exp_s    = small_sigma1(w_win_r[14]) + w_win_r[9] + small_sigma0(w_win_r[1]) + w_win_r[0];
    accept_s   = 1'b0;
    shift_s    = 1'b0;
    w_s        = w_exp_s;
    round_in_s = vars_r;
    if (state_r == ST_IDLE) begin
      accept_s = write_enable;
      shift_s  = write_enable;
      w_s      = data;
      if (t_r == 6'd0) begin
        if (first_block) begin
          round_in_s = IV;
        end else begin
          round_in_s = h_r;
        end
      end else begin
        round_in_s = vars_r;
      end
    end else if (state_r == ST_RUN) begin
      shift_s = 1'b1;
    end else begin
      shift_s = 1'b0;
    end
    // H is only committed at block end, so an aborted first block leaves it intact.
    if (first_r) begin
      h_base_s = IV;
    end else begin
      h_base_s = h_r;
    end
  end

  // Message schedule window; entry 15 holds the most recent W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) w_win_r[i] <= 32'd0;
    end else if (shift_s) begin
      for (int i = 0; i < 15; i++) w_win_r[i] <= w_win_r[i + 1];
      w_win_r[15] <= w_s;
    end
  end

  // Control FSM, working variables, chained hash and digest output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      t_r       <= 6'd0;
      out_cnt_r <= 4'd0;
      first_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
      oe_r      <= 1'b0;
      digest_r  <= 32'd0;
      vars_r    <= '0;
      h_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            vars_r <= round_out_s;
            t_r    <= t_r + 6'd1;
            if (t_r == 6'd0) begin
              first_r <= first_block;
              last_r  <= last_block;
            end
            if (t_r == 6'd15) begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end else begin
`ifdef SHA256_WRITE_STALL_EN
            t_r <= t_r;
`else
            t_r <= 6'd0;
`endif
          end
        end
        ST_RUN: begin
          vars_r <= round_out_s;
          t_r    <= t_r + 6'd1;
          if (t_r == 6'd63) begin
            state_r <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) h_r[i] <= h_base_s[i] + vars_r[i];
          if (last_r) begin
            state_r   <= ST_OUT;
            oe_r      <= 1'b1;
            digest_r  <= 32'd0;
            out_cnt_r <= 4'd0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_OUT: begin
          if (out_cnt_r == 4'd8) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            oe_r     <= 1'b0;
            digest_r <= 32'd0;
          end else begin
            digest_r  <= h_r[out_cnt_r[2:0]];
            out_cnt_r <= out_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: reference SHA-256 model, decoupled digest monitor.
`timescale 1ns/1ps
module tb_sha256_stream_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = 32'd0;
  logic        write_enable = 1'b0;
  logic        first_block = 1'b0;
  logic        last_block = 1'b0;
  logic        busy;
  logic [31:0] digest;
  logic        output_enable;

  sha256_stream_core dut (
    .clk           (clk),
    .reset         (reset),
    .data          (data),
    .write_enable  (write_enable),
    .first_block   (first_block),
    .last_block    (last_block),
    .busy          (busy),
    .digest        (digest),
    .output_enable (output_enable)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] TB_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ZERO56_D = 256'hbd03ac14_28f0ea86_f4b83a73_1ffc7967_bb82866d_8545322f_888d2f6e_857ffc18;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int w15_cyc = 0;
  logic [255:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one 512-bit block onto chaining value hin (H0 in the MSBs).
  function automatic logic [255:0] ref_block(input logic [255:0] hin, input logic [31:0] blk [16]);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] t1;
    logic [31:0] t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int i = 0; i < 64; i++) begin
      if (i < 16) w[i] = blk[i];
      else w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + TB_K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hh[i] + v[i];
    return res;
  endfunction

  // Issue one block starting at a negedge; gap_after >= 0 inserts one idle cycle after that word.
  task automatic send_block(input logic [31:0] blk [16], input logic first, input logic last, input int gap_after);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_block", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      data         = blk[i];
      write_enable = 1'b1;
      first_block  = (i == 0) ? first : 1'($urandom);
      last_block   = (i == 0) ? last  : 1'($urandom);
      @(negedge clk);
      if (i == gap_after) begin
        write_enable = 1'b0;
        data         = $urandom;
        @(negedge clk);
        check("busy_low_in_gap", {31'd0, busy}, 32'd0);
      end
    end
    write_enable = 1'b0;
    first_block  = 1'b0;
    last_block   = 1'b0;
    w15_cyc      = cyc;
    if (gap_after < 0) check("busy_after_w15", {31'd0, busy}, 32'd1);
  endtask

  // Keep writing while the engine is busy; all of these must be ignored.
  task automatic hammer(input int n);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      if (busy !== 1'b1) bad++;
      data         = $urandom;
      write_enable = 1'b1;
      first_block  = 1'($urandom);
      last_block   = 1'($urandom);
      @(negedge clk);
    end
    write_enable = 1'b0;
    first_block  = 1'b0;
    last_block   = 1'b0;
    check("busy_during_run_out", bad, 32'd0);
  endtask

  // Digest monitor: pops one expected digest per output phase.
  initial begin
    logic [255:0] cur_exp;
    int oe_run;
    cur_exp = '0;
    oe_run  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        oe_run = 0;
      end else if (output_enable) begin
        if (oe_run == 0) begin
          check("lead_in_zero", digest, 32'd0);
          check("oe_start_after_w15", cyc - w15_cyc, 32'd49);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: digest phase started, got oe=1 expected none pending");
            cur_exp = '0;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end else if (oe_run <= 8) begin
          check($sformatf("digest_word%0d", oe_run - 1), digest, cur_exp[255 - 32*(oe_run - 1) -: 32]);
        end else begin
          check("oe_phase_too_long", oe_run, 32'd8);
        end
        oe_run++;
      end else begin
        if (oe_run != 0) check("oe_phase_length", oe_run, 32'd9);
        oe_run = 0;
      end
    end
  end

  initial begin
    logic [31:0] abc [16];
    logic [31:0] z1 [16];
    logic [31:0] z2 [16];
    logic [31:0] rb [16];
    logic [255:0] h;
    int nb;
    int n;

    for (int i = 0; i < 16; i++) begin
      abc[i] = 32'd0;
      z1[i]  = (i < 14) ? 32'h30303030 : ((i == 14) ? 32'h80000000 : 32'd0);
      z2[i]  = 32'd0;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    z2[15]  = 32'h000001c0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_oe", {31'd0, output_enable}, 32'd0);
    check("reset_digest", digest, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-block message of 56 '0' characters.
    exp_q.push_back(ZERO56_D);
    send_block(z1, 1'b1, 1'b0, -1);
    send_block(z2, 1'b0, 1'b1, -1);

    // Single block "abc" with writes hammered throughout RUN/FINAL/OUT.
    exp_q.push_back(ABC_D);
    send_block(abc, 1'b1, 1'b1, -1);
    hammer(57);

    // Reset mid-RUN aborts immediately, then a clean "abc".
    send_block(abc, 1'b1, 1'b1, -1);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_oe", {31'd0, output_enable}, 32'd0);
    check("abort_digest", digest, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(ABC_D);
    send_block(abc, 1'b1, 1'b1, -1);

    // Write gap after word 5.
`ifdef SHA256_WRITE_STALL_EN
    exp_q.push_back(ABC_D);
    send_block(abc, 1'b1, 1'b1, 5);
`else
    send_block(abc, 1'b1, 1'b1, 5);
    repeat (70) @(negedge clk);
    exp_q.push_back(ABC_D);
    send_block(abc, 1'b1, 1'b1, -1);
`endif

    // Random multi-block messages against the reference model.
    for (int m = 0; m < 4; m++) begin
      nb = $urandom_range(1, 3);
      h  = TB_IV;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) rb[i] = $urandom;
        h = ref_block(h, rb);
        if (b == nb - 1) exp_q.push_back(h);
        send_block(rb, (b == 0) ? 1'b1 : 1'b0, (b == nb - 1) ? 1'b1 : 1'b0, -1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    n = 0;
    while ((exp_q.size() != 0 || output_enable === 1'b1 || busy === 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("pending_digests", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
